// File: rtl/ready_packets_pkg.sv
// Shared constants for the receive byte buffer and the transport layer above it.
// No logic; defaults only.
// Header byte values are interpreted by the transport side, never by the FIFO.
package ready_packets_pkg;

    // Default geometry: byte-wide, 1024 deep, count wide enough to hold DEPTH itself.
    localparam int RP_WIDTH = 8;
    localparam int RP_DEPTH = 1024;
    localparam int RP_CNT_W = 11;

    // First byte of a buffered packet identifies its type.
    typedef enum logic [7:0] {
        HDR_CTRL  = 8'h40,
        HDR_AUDIO = 8'h80
    } hdr_byte_e;

endpackage

// File: rtl/ready_packets_ram.sv
// Simple dual-port storage: one synchronous write port, one registered read port.
// Latency: write visible to a read issued the following cycle; read data one cycle after re_i.
// No flow control of its own; the caller guarantees legal addresses and enables.
module ready_packets_ram
    import ready_packets_pkg::*;
#(
    parameter int WIDTH = RP_WIDTH,
    parameter int DEPTH = RP_DEPTH,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             srst_i,
    input  logic             we_i,
    input  logic [AW-1:0]    waddr_i,
    input  logic [WIDTH-1:0] wdat_i,
    input  logic             re_i,
    input  logic [AW-1:0]    raddr_i,
    output logic [WIDTH-1:0] rdat_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] rdat_q;

    // Storage array is deliberately left unreset so it maps onto block RAM.
    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdat_i;
        end
    end

    // Output register: cleared by reset, otherwise holds until the next accepted read.
    always_ff @(posedge clk) begin
        if (srst_i) begin
            rdat_q <= '0;
        end else if (re_i) begin
            rdat_q <= mem_q[raddr_i];
        end
    end

    assign rdat_o = rdat_q;

endmodule

// File: rtl/ready_packets.sv
// Byte FIFO between the network receive side and transport receive logic (standard, not FWFT).
// Latency: dout valid the cycle after an accepted rd_en; flags/count update on the write/read edge.
// Backpressure: writes dropped silently while full, reads ignored while empty; no error flags.
module ready_packets
    import ready_packets_pkg::*;
#(
    parameter int WIDTH = RP_WIDTH,
    parameter int DEPTH = RP_DEPTH,
    parameter int CNT_W = RP_CNT_W
) (
    input  logic             clk,
    input  logic             srst,
    input  logic [WIDTH-1:0] din,
    input  logic             wr_en,
    input  logic             rd_en,
    output logic [WIDTH-1:0] dout,
    output logic             empty,
    output logic             full,
    output logic [CNT_W-1:0] data_count
);

    // DEPTH is a power of two, so pointers wrap naturally by overflowing AW bits.
    localparam int AW = $clog2(DEPTH);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [AW-1:0]    PTR_ONE  = AW'(1);

    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             empty_q, empty_d;
    logic             full_q, full_d;
    logic             wr_acc;
    logic             rd_acc;

    // Acceptance uses only registered flags, so a same-cycle read never frees space for a
    // write and a same-cycle write never supplies data for a read.
    always_comb begin
        wr_acc   = wr_en && !full_q;
        rd_acc   = rd_en && !empty_q;
        wr_ptr_d = wr_acc ? (wr_ptr_q + PTR_ONE) : wr_ptr_q;
        rd_ptr_d = rd_acc ? (rd_ptr_q + PTR_ONE) : rd_ptr_q;
        count_d  = count_q;
        unique case ({wr_acc, rd_acc})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
        endcase
        empty_d  = (count_d == '0);
        full_d   = (count_d == CNT_FULL);
    end

    // Pointer, occupancy and flag registers; flags derive from the next count so they
    // always agree with data_count.
    always_ff @(posedge clk) begin
        if (srst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            empty_q  <= 1'b1;
            full_q   <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            empty_q  <= empty_d;
            full_q   <= full_d;
        end
    end

    // Read and write addresses never collide on an accepted pair: equal pointers imply
    // either empty (read rejected) or full (write rejected).
    ready_packets_ram #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_ram (
        .clk     (clk),
        .srst_i  (srst),
        .we_i    (wr_acc),
        .waddr_i (wr_ptr_q),
        .wdat_i  (din),
        .re_i    (rd_acc),
        .raddr_i (rd_ptr_q),
        .rdat_o  (dout)
    );

    assign empty      = empty_q;
    assign full       = full_q;
    assign data_count = count_q;

endmodule

// File: tb/tb_ready_packets.sv
// Randomized scoreboard bench for the receive byte FIFO.
// The reference model is a plain byte queue; reads predicted by the model queue their
// expected byte, and a monitor checks dout whenever the DUT performs a read handshake.
module tb_ready_packets;
    import ready_packets_pkg::*;

    localparam int DEPTH = 1024;

    logic        clk = 1'b0;
    logic        srst;
    logic [7:0]  din;
    logic        wr_en;
    logic        rd_en;
    logic [7:0]  dout;
    logic        empty;
    logic        full;
    logic [10:0] data_count;

    always #5 clk = ~clk;

    ready_packets dut (
        .clk        (clk),
        .srst       (srst),
        .din        (din),
        .wr_en      (wr_en),
        .rd_en      (rd_en),
        .dout       (dout),
        .empty      (empty),
        .full       (full),
        .data_count (data_count)
    );

    int          n_tests = 0;
    int          n_fail  = 0;
    logic [7:0]  model_q [$];
    logic [7:0]  exp_q [$];
    logic [7:0]  last_dout;
    bit          mon_hs;
    bit          aa_seen;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // One clock: drive at negedge, advance model at posedge, check occupancy just after.
    task automatic cycle(input bit w, input logic [7:0] d, input bit r, input bit rst);
        bit acc_w;
        @(negedge clk);
        wr_en = w;
        din   = d;
        rd_en = r;
        srst  = rst;
        @(posedge clk);
        if (rst) begin
            model_q.delete();
            exp_q.delete();
            last_dout = 8'h00;
        end else begin
            acc_w = w && (model_q.size() < DEPTH);
            if (r && model_q.size() > 0) begin
                last_dout = model_q.pop_front();
                exp_q.push_back(last_dout);
            end
            if (acc_w) model_q.push_back(d);
        end
        #1;
        check("data_count", data_count, model_q.size());
        check("empty", empty, model_q.size() == 0);
        check("full", full, model_q.size() == DEPTH);
    endtask

    // Monitor: a read handshake at an edge means dout must carry the next expected byte.
    always @(posedge clk) begin
        mon_hs = (rd_en === 1'b1) && (empty === 1'b0) && (srst === 1'b0);
        #1;
        if (mon_hs) begin
            if (exp_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_read: dout=%0h with no read predicted", dout);
            end else begin
                check("dout", dout, exp_q.pop_front());
            end
            if (dout == 8'hAA) aa_seen = 1'b1;
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, tests=%0d failed=%0d", n_tests, n_fail);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] d;
        int guard;
        srst = 1'b1; wr_en = 1'b0; rd_en = 1'b0; din = 8'h00;
        last_dout = 8'h00;
        aa_seen = 1'b0;

        // Reset then idle
        cycle(0, 8'h00, 0, 1);
        cycle(0, 8'h00, 0, 1);
        cycle(0, 8'h00, 0, 0);
        check("reset_dout", dout, 8'h00);

        // Packet of 16 bytes: audio header then 01..0F, then drain
        for (int i = 0; i < 16; i++) begin
            d = (i == 0) ? HDR_AUDIO : 8'(i);
            cycle(1, d, 0, 0);
        end
        check("count_16", data_count, 16);
        for (int i = 0; i < 16; i++) cycle(0, 8'h00, 1, 0);
        check("drain_last_dout", dout, 8'h0F);
        check("drain_empty", empty, 1);

        // Reads while empty hold dout
        for (int i = 0; i < 3; i++) cycle(0, 8'h00, 1, 0);
        check("empty_read_hold", dout, 8'h0F);
        // Read while empty with a write: read ignored, word readable next cycle
        cycle(1, 8'h33, 1, 0);
        check("empty_rw_hold", dout, 8'h0F);
        check("empty_rw_count", data_count, 1);
        cycle(0, 8'h00, 1, 0);
        check("empty_rw_read", dout, 8'h33);

        // Fill completely with bytes other than AA
        for (int i = 0; i < DEPTH; i++) begin
            d = 8'($urandom);
            if (d == 8'hAA) d = 8'h5A;
            cycle(1, d, 0, 0);
        end
        check("fill_full", full, 1);
        check("fill_count", data_count, 1024);
        cycle(1, 8'hAA, 0, 0);
        check("full_write_count", data_count, 1024);
        cycle(1, 8'hAA, 1, 0);
        check("full_rw_count", data_count, 1023);
        for (int i = 0; i < DEPTH - 1; i++) cycle(0, 8'h00, 1, 0);
        check("no_AA_read", aa_seen, 0);
        check("after_fill_empty", empty, 1);

        // Count 5, then simultaneous read/write keeps occupancy
        for (int i = 0; i < 5; i++) cycle(1, 8'($urandom), 0, 0);
        for (int i = 0; i < 10; i++) cycle(1, 8'($urandom), 1, 0);
        check("rw_count_5", data_count, 5);

        // Random traffic across pointer wrap
        for (int i = 0; i < 1500; i++)
            cycle(bit'($urandom_range(0, 99) < 55), 8'($urandom),
                  bit'($urandom_range(0, 99) < 50), 0);

        // Build up to exactly 300 while reading, then reset mid-burst
        guard = 0;
        while (model_q.size() < 300 && guard < 5000) begin
            cycle(1, 8'($urandom), bit'($urandom_range(0, 3) == 0), 0);
            guard++;
        end
        while (model_q.size() > 300 && guard < 5000) begin
            cycle(0, 8'h00, 1, 0);
            guard++;
        end
        check("pre_reset_count", data_count, 300);
        cycle(1, 8'h11, 1, 1);
        check("midburst_reset_dout", dout, 8'h00);
        check("midburst_reset_empty", empty, 1);
        cycle(1, 8'h55, 0, 0);
        cycle(0, 8'h00, 1, 0);
        check("post_reset_55", dout, 8'h55);

        cycle(0, 8'h00, 0, 0);
        check("scoreboard_drained", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
